id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Parametrised, registered successor to the combinational decode stage of the RISC-V CPU.
- Decodes one RV32I instruction per cycle and resolves operands through NUM_FWD prioritised forwarding channels.
- Detects load-use hazards and inserts one bubble per hazard; honours a branch flush.
- Holds the result in an ID/EX output register with a valid/ready handshake on both sides.
- Sits between IF (upstream) and EX (downstream); the register file is read combinationally.

Parameters:
- XLEN, 32, data and PC width.
- OPW, 11, width of opcode_out: {bit30, funct3, opcode[6:0]}.
- NUM_FWD, 2, number of forwarding sources; index 0 is the youngest and has the highest priority.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  ID accepts the instruction this cycle.
- inst_in  in  32  instruction word.
- pc_in  in  XLEN  PC of inst_in.
- rs1_addr_out  out  5  register-file read address 1 (combinational from inst_in).
- rs2_addr_out  out  5  register-file read address 2 (combinational from inst_in).
- rdata1_in  in  XLEN  register-file data for rs1.
- rdata2_in  in  XLEN  register-file data for rs2.
- fwd_valid_in  in  NUM_FWD  per-channel write-back valid.
- fwd_rd_in  in  5*NUM_FWD  per-channel destination register (packed).
- fwd_data_in  in  XLEN*NUM_FWD  per-channel result (packed).
- flush_in  in  1  branch/jump mispredict kill from EX.
- out_valid  out  1  ID/EX register holds a real instruction.
- out_ready  in  1  EX accepts the register contents.
- opcode_out  out  OPW  encoded operation.
- rd_out  out  5  destination register; 0 if there is no write.
- data1_out  out  XLEN  resolved rs1 operand.
- data2_out  out  XLEN  resolved rs2 operand.
- imm_out  out  XLEN  sign-extended immediate.
- pc_out  out  XLEN  instruction PC.
- is_load_out  out  1  instruction is a LOAD.
- illegal_out  out  1  unknown opcode; the instruction is passed as a NOP with this flag set.

Behaviour:
- Reset: clk and rst as named above; reset is synchronous and active-high. When rst is high at an edge, every registered output clears to 0 (out_valid, opcode_out, rd_out, data1_out, data2_out, imm_out, pc_out, is_load_out, illegal_out). in_ready is 0 while rst is high. Reset mid-handshake discards the in-flight instruction.
- Decode (combinational):
  - Source addresses: rs1 = inst[19:15] for R, I, LOAD, JALR, S and B formats; rs2 = inst[24:20] for R, S and B formats; otherwise 0.
  - rd = inst[11:7] for R, I, LOAD, JALR, U and JAL formats; 0 for S and B.
  - Immediates: I = sext(inst[31:20]); S = sext({inst[31:25], inst[11:7]}); B = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}); U = {inst[31:12], 12'b0}; J = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - opcode_out bit10 = inst[30] only for OP, and for OP-IMM when funct3 = 101; otherwise 0.
  - funct3 field = inst[14:12], except 000 for LUI, AUIPC and JAL.
- Operand resolution:
  - If rsN = 0, the operand is 0.
  - Otherwise use the lowest-index channel i with fwd_valid_in[i] set and fwd_rd_in[i] == rsN.
  - If no channel matches, use rdataN_in.
  - Any unused operand (rs = 0) is 0.
- Load-use hazard: hazard = out_valid && is_load_out && rd_out != 0 && (rd_out == rs1 || rd_out == rs2) of the incoming instruction, with in_valid high.
- Register advance: adv = out_ready || !out_valid.
- Input handshake: in_ready = adv && !hazard && !flush_in && !rst.
- At each edge when adv is high:
  - If flush_in: out_valid <= 0 (the input is also dropped; IF is redirected).
  - Else if hazard: out_valid <= 0 (bubble); the instruction is held upstream.
  - Else: out_valid <= in_valid, and all fields load from decode.
- When adv is low, all outputs hold; this includes during flush_in. EX is responsible for squashing its own slot.
- Latency: exactly 1 cycle from acceptance to out_valid. Throughput is 1 per cycle when there are no hazards.
- Simultaneous events:
  - flush_in has priority over hazard.
  - A forwarding match has priority over register-file data.
  - A hazard bubble lasts exactly 1 cycle, because the load then leaves the ID/EX register and later resolves via forwarding.
- Illegal opcode: opcode_out = 0, rd_out = 0, operands = 0, illegal_out = 1, pc_out preserved.

Decomposition:
- Shared package riscv_pkg: opcode constants (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE), XLEN, OPW, and a decode struct type {opcode, rd, rs1, rs2, imm, is_load, illegal}.
- One sub-module, id_decode_comb: a purely combinational instruction-to-struct decoder.
- id_stage_pipe owns forwarding, hazard logic and the output register.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rdata1 = 5, rdata2 = 7, no forwarding -> next cycle out_valid = 1, opcode_out = 0x033, rd_out = 3, data1_out = 5, data2_out = 7.
- Forwarding priority: fwd0 = {x1, 0xAA}, fwd1 = {x1, 0xBB}, both valid, ADDI x4,x1,-1 -> data1_out = 0xAA, imm_out = 0xFFFFFFFF, opcode bit10 = 0. With fwd_rd = 0, x0 read -> operand = 0.
- LW x5,0(x1) followed by ADD x6,x5,x5 -> one cycle with in_ready = 0 and a bubble (out_valid = 0), then the ADD issues with fwd0 = {x5, 0x1234} giving data1_out = data2_out = 0x1234.
- out_ready held low for 3 cycles with a valid entry -> outputs stable and in_ready = 0; on release, a back-to-back stream resumes at 1 instruction per cycle.
- flush_in pulsed together with in_valid and a hazard -> out_valid = 0 next cycle and in_ready = 0 that cycle. rst asserted mid-stream -> all outputs 0 on the following edge.
- Illegal opcode 0x0000007F at pc 0x40 -> illegal_out = 1, rd_out = 0, pc_out = 0x40. JAL 0x008000EF -> rd_out = 1, imm_out = 8, funct3 = 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode constants, widths and the decode record
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int OPW  = 11;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef struct packed {
        logic [OPW-1:0] opcode;
        logic [4:0]     rd;
        logic [4:0]     rs1;
        logic [4:0]     rs2;
        logic [31:0]    imm;
        logic           is_load;
        logic           illegal;
    } decode_t;

endpackage

// File: rtl/id_stage_pipe_if.sv
// rtl/id_stage_pipe_if.sv - ID/EX output bus with valid/ready handshake
interface id_stage_pipe_if #(
    parameter int XLEN = 32,
    parameter int OPW  = 11
);
    logic            out_valid;
    logic            out_ready;
    logic [OPW-1:0]  opcode_out;
    logic [4:0]      rd_out;
    logic [XLEN-1:0] data1_out;
    logic [XLEN-1:0] data2_out;
    logic [XLEN-1:0] imm_out;
    logic [XLEN-1:0] pc_out;
    logic            is_load_out;
    logic            illegal_out;

    modport master (
        output out_valid, opcode_out, rd_out, data1_out, data2_out,
               imm_out, pc_out, is_load_out, illegal_out,
        input  out_ready
    );

    modport slave (
        input  out_valid, opcode_out, rd_out, data1_out, data2_out,
               imm_out, pc_out, is_load_out, illegal_out,
        output out_ready
    );
endinterface

// File: rtl/id_decode_comb.sv
// rtl/id_decode_comb.sv - combinational RV32I instruction to decode record
module id_decode_comb
    import riscv_pkg::*;
(
    input  logic [31:0] inst,
    output decode_t     dec
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic       bit10;
    logic       use_rs1;
    logic       use_rs2;
    logic       use_rd;
    logic       illegal;

    assign opc = inst[6:0];

    always_comb begin
        f3      = inst[14:12];
        bit10   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        illegal = 1'b0;
        dec     = '0;
        case (opc)
            OPC_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                bit10   = inst[30];
            end
            OPC_OP_IMM: begin
                use_rs1 = 1'b1; use_rd = 1'b1;
                bit10   = (inst[14:12] == 3'b101) ? inst[30] : 1'b0;
                dec.imm = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1; use_rd = 1'b1;
                dec.is_load = 1'b1;
                dec.imm = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_JALR: begin
                use_rs1 = 1'b1; use_rd = 1'b1;
                dec.imm = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                use_rd  = 1'b1;
                f3      = 3'b000;
                dec.imm = {inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                use_rd  = 1'b1;
                f3      = 3'b000;
                dec.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: illegal = 1'b1;
        endcase
        // Unknown opcodes travel as a NOP: every field zero except the flag.
        dec.rs1     = use_rs1 ? inst[19:15] : 5'd0;
        dec.rs2     = use_rs2 ? inst[24:20] : 5'd0;
        dec.rd      = use_rd  ? inst[11:7]  : 5'd0;
        dec.opcode  = illegal ? '0 : {bit10, f3, opc};
        dec.illegal = illegal;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - registered RV32I decode stage with forwarding and load-use stall
module id_stage_pipe #(
    parameter int XLEN    = riscv_pkg::XLEN,
    parameter int OPW     = riscv_pkg::OPW,
    parameter int NUM_FWD = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             inst_in,
    input  logic [XLEN-1:0]         pc_in,
    output logic [4:0]              rs1_addr_out,
    output logic [4:0]              rs2_addr_out,
    input  logic [XLEN-1:0]         rdata1_in,
    input  logic [XLEN-1:0]         rdata2_in,
    input  logic [NUM_FWD-1:0]      fwd_valid_in,
    input  logic [5*NUM_FWD-1:0]    fwd_rd_in,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data_in,
    input  logic                    flush_in,
    id_stage_pipe_if.master         ex
);
    import riscv_pkg::*;

    decode_t dec;

    logic            valid_q, valid_d;
    logic [OPW-1:0]  opcode_q, opcode_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] data1_q, data1_d;
    logic [XLEN-1:0] data2_q, data2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            is_load_q, is_load_d;
    logic            illegal_q, illegal_d;
    logic            adv;
    logic            hazard;

    id_decode_comb u_decode (
        .inst (inst_in),
        .dec  (dec)
    );

    // Walk from the oldest channel down so the youngest match wins.
    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]              rs,
        input logic [XLEN-1:0]         rf,
        input logic [NUM_FWD-1:0]      fv,
        input logic [5*NUM_FWD-1:0]    frd,
        input logic [XLEN*NUM_FWD-1:0] fdat
    );
        logic [XLEN-1:0] r;
        r = rf;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fv[i] && frd[i*5 +: 5] == rs) r = fdat[i*XLEN +: XLEN];
        end
        if (rs == 5'd0) r = '0;
        return r;
    endfunction

    assign rs1_addr_out = dec.rs1;
    assign rs2_addr_out = dec.rs2;

    assign adv    = ex.out_ready || !valid_q;
    assign hazard = in_valid && valid_q && is_load_q && (rd_q != 5'd0) &&
                    (rd_q == dec.rs1 || rd_q == dec.rs2);
    assign in_ready = adv && !hazard && !flush_in && !rst;

    always_comb begin
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        rd_d      = rd_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        is_load_d = is_load_q;
        illegal_d = illegal_q;
        if (adv) begin
            if (flush_in || hazard) begin
                valid_d = 1'b0;
            end else begin
                valid_d   = in_valid;
                opcode_d  = OPW'(dec.opcode);
                rd_d      = dec.rd;
                data1_d   = resolve(dec.rs1, rdata1_in, fwd_valid_in, fwd_rd_in, fwd_data_in);
                data2_d   = resolve(dec.rs2, rdata2_in, fwd_valid_in, fwd_rd_in, fwd_data_in);
                imm_d     = XLEN'(signed'(dec.imm));
                pc_d      = pc_in;
                is_load_d = dec.is_load;
                illegal_d = dec.illegal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            rd_q      <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            is_load_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            rd_q      <= rd_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            is_load_q <= is_load_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex.out_valid   = valid_q;
    assign ex.opcode_out  = opcode_q;
    assign ex.rd_out      = rd_q;
    assign ex.data1_out   = data1_q;
    assign ex.data2_out   = data2_q;
    assign ex.imm_out     = imm_q;
    assign ex.pc_out      = pc_q;
    assign ex.is_load_out = is_load_q;
    assign ex.illegal_out = illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - scoreboard bench for id_stage_pipe
module tb_id_stage_pipe;

    localparam int XLEN = 32;
    localparam int OPW  = 11;
    localparam int NF   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst_in;
    logic [XLEN-1:0] pc_in;
    logic [4:0]      rs1_addr_out;
    logic [4:0]      rs2_addr_out;
    logic [XLEN-1:0] rdata1_in;
    logic [XLEN-1:0] rdata2_in;
    logic [NF-1:0]   fwd_valid_in;
    logic [5*NF-1:0] fwd_rd_in;
    logic [XLEN*NF-1:0] fwd_data_in;
    logic            flush_in;

    id_stage_pipe_if #(.XLEN(XLEN), .OPW(OPW)) ex_if ();

    id_stage_pipe #(.XLEN(XLEN), .OPW(OPW), .NUM_FWD(NF)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .inst_in      (inst_in),
        .pc_in        (pc_in),
        .rs1_addr_out (rs1_addr_out),
        .rs2_addr_out (rs2_addr_out),
        .rdata1_in    (rdata1_in),
        .rdata2_in    (rdata2_in),
        .fwd_valid_in (fwd_valid_in),
        .fwd_rd_in    (fwd_rd_in),
        .fwd_data_in  (fwd_data_in),
        .flush_in     (flush_in),
        .ex           (ex_if.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] opc;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        ld;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   c0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [10:0] o, input logic [4:0] rd,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] imm, input logic [31:0] pc,
                                input logic ld, input logic ill);
        exp_t e;
        e.opc = o; e.rd = rd; e.d1 = d1; e.d2 = d2;
        e.imm = imm; e.pc = pc; e.ld = ld; e.ill = ill;
        return e;
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && ex_if.out_valid === 1'b1 && ex_if.out_ready === 1'b1) begin
            exp_t a, e;
            a = mk(ex_if.opcode_out, ex_if.rd_out, ex_if.data1_out, ex_if.data2_out,
                   ex_if.imm_out, ex_if.pc_out, ex_if.is_load_out, ex_if.illegal_out);
            total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_out: got pc 0x%0h required no output", a.pc);
            end else begin
                e = sb.pop_front();
                if (a === e) passed++;
                else $display("FAIL out_entry pc=0x%0h: got %h required %h", e.pc, a, e);
            end
        end
    end

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
        bit done;
        done = 1'b0;
        inst_in = inst; pc_in = pc; rdata1_in = r1; rdata2_in = r2; in_valid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) check_eq("issue_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; inst_in = '0; pc_in = '0;
        rdata1_in = '0; rdata2_in = '0; fwd_valid_in = '0; fwd_rd_in = '0;
        fwd_data_in = '0; flush_in = 1'b0; ex_if.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_out_valid", {31'd0, ex_if.out_valid}, 32'd0);
        check_eq("reset_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("reset_opcode", {21'd0, ex_if.opcode_out}, 32'd0);
        rst = 1'b0;

        issue(32'h002081B3, 32'h00, 32'd5, 32'd7, mk(11'h033, 5'd3, 32'd5, 32'd7, 32'd0, 32'h00, 1'b0, 1'b0));
        fwd_valid_in = 2'b11; fwd_rd_in = {5'd1, 5'd1}; fwd_data_in = {32'hBB, 32'hAA};
        issue(32'hFFF08213, 32'h04, 32'h55, 32'h66, mk(11'h013, 5'd4, 32'hAA, 32'd0, 32'hFFFFFFFF, 32'h04, 1'b0, 1'b0));
        fwd_rd_in = {5'd2, 5'd0}; fwd_data_in = {32'hDD, 32'hCC};
        issue(32'h002003B3, 32'h08, 32'h99, 32'h77, mk(11'h033, 5'd7, 32'd0, 32'hDD, 32'd0, 32'h08, 1'b0, 1'b0));
        fwd_valid_in = 2'b00;
        issue(32'h40208433, 32'h0C, 32'd10, 32'd3, mk(11'h433, 5'd8, 32'd10, 32'd3, 32'd0, 32'h0C, 1'b0, 1'b0));
        issue(32'h4030D493, 32'h10, 32'h80000000, 32'h1, mk(11'h693, 5'd9, 32'h80000000, 32'd0, 32'h403, 32'h10, 1'b0, 1'b0));

        issue(32'h0000A283, 32'h14, 32'h100, 32'h2, mk(11'h103, 5'd5, 32'h100, 32'd0, 32'd0, 32'h14, 1'b1, 1'b0));
        inst_in = 32'h00528333; pc_in = 32'h18; rdata1_in = 32'h9999; rdata2_in = 32'h9999;
        fwd_valid_in = 2'b01; fwd_rd_in = {5'd0, 5'd5}; fwd_data_in = {32'h0, 32'h1234};
        @(negedge clk);
        check_eq("hazard_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("hazard_load_valid", {31'd0, ex_if.out_valid}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("bubble_out_valid", {31'd0, ex_if.out_valid}, 32'd0);
        check_eq("bubble_in_ready", {31'd0, in_ready}, 32'd1);
        if (in_ready) sb.push_back(mk(11'h033, 5'd6, 32'h1234, 32'h1234, 32'd0, 32'h18, 1'b0, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0; fwd_valid_in = 2'b00;
        @(posedge clk); #1;

        ex_if.out_ready = 1'b0;
        issue(32'h002081B3, 32'h20, 32'd1, 32'd2, mk(11'h033, 5'd3, 32'd1, 32'd2, 32'd0, 32'h20, 1'b0, 1'b0));
        inst_in = 32'h00500513; pc_in = 32'h24;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("stall_hold_pc", ex_if.pc_out, 32'h20);
            @(posedge clk); #1;
        end
        ex_if.out_ready = 1'b1;
        c0 = cyc;
        issue(32'h00500513, 32'h24, 32'h5A, 32'd0, mk(11'h013, 5'd10, 32'd0, 32'd0, 32'd5, 32'h24, 1'b0, 1'b0));
        issue(32'h123455B7, 32'h28, 32'd0, 32'd0, mk(11'h037, 5'd11, 32'd0, 32'd0, 32'h12345000, 32'h28, 1'b0, 1'b0));
        issue(32'h0020A423, 32'h2C, 32'h1000, 32'hBEEF, mk(11'h123, 5'd0, 32'h1000, 32'hBEEF, 32'd8, 32'h2C, 1'b0, 1'b0));
        check_eq("stream_cycles", cyc - c0, 32'd3);

        issue(32'h0000A283, 32'h60, 32'h200, 32'd0, mk(11'h103, 5'd5, 32'h200, 32'd0, 32'd0, 32'h60, 1'b1, 1'b0));
        inst_in = 32'h00528333; pc_in = 32'h64; flush_in = 1'b1;
        @(negedge clk);
        check_eq("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush_in = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_out_valid", {31'd0, ex_if.out_valid}, 32'd0);
        @(posedge clk); #1;

        issue(32'h0000007F, 32'h40, 32'h11, 32'h22, mk(11'h000, 5'd0, 32'd0, 32'd0, 32'd0, 32'h40, 1'b0, 1'b1));
        issue(32'h008000EF, 32'h44, 32'h11, 32'h22, mk(11'h06F, 5'd1, 32'd0, 32'd0, 32'd8, 32'h44, 1'b0, 1'b0));
        in_valid = 1'b0;
        @(posedge clk); #1;

        issue(32'h002081B3, 32'h80, 32'd3, 32'd4, mk(11'h033, 5'd3, 32'd3, 32'd4, 32'd0, 32'h80, 1'b0, 1'b0));
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        sb.delete();
        check_eq("rst_out_valid", {31'd0, ex_if.out_valid}, 32'd0);
        check_eq("rst_fields", ex_if.data1_out | ex_if.data2_out | ex_if.imm_out | ex_if.pc_out |
                 {16'd0, ex_if.opcode_out, ex_if.rd_out} |
                 {30'd0, ex_if.is_load_out, ex_if.illegal_out}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;

        issue(32'h00500513, 32'h90, 32'h1, 32'h2, mk(11'h013, 5'd10, 32'd0, 32'd0, 32'd5, 32'h90, 1'b0, 1'b0));
        in_valid = 1'b0;
        for (int n = 0; n < 10 && sb.size() != 0; n++) @(posedge clk);
        #1;
        check_eq("scoreboard_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
